// File: rtl/pipeline_ctrl_unit.sv
// Pipeline hazard/stall controller: per-stage enables, flushes, stage-valid bits and a data-memory watchdog.
// Optional saturating performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl_unit #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_load_i,
  input  logic branch_taken_EX_i,
  input  logic dmem_req_MEM_i,
  input  logic dmem_ready_i,
  output logic pc_en_o,
  output logic if_id_en_o,
  output logic id_ex_en_o,
  output logic ex_mem_en_o,
  output logic mem_wb_en_o,
  output logic if_id_flush_o,
  output logic id_ex_flush_o,
  output logic mem_wb_flush_o,
  output logic valid_ID_o,
  output logic valid_EX_o,
  output logic valid_MEM_o,
  output logic valid_WB_o,
  output logic fault_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_stall_load_o,
  output logic [CNT_WIDTH-1:0] perf_mem_wait_o,
  output logic [CNT_WIDTH-1:0] perf_flush_o
`endif
);
  localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          vld_id_q, vld_ex_q, vld_mem_q, vld_wb_q;
  logic          mem_wait, br_apply, ld_apply;

  assign mem_wait    = dmem_req_MEM_i & vld_mem_q & ~dmem_ready_i;
  assign valid_ID_o  = vld_id_q;
  assign valid_EX_o  = vld_ex_q;
  assign valid_MEM_o = vld_mem_q;
  assign valid_WB_o  = vld_wb_q;

  always_comb begin
    pc_en_o        = 1'b1;
    if_id_en_o     = 1'b1;
    id_ex_en_o     = 1'b1;
    ex_mem_en_o    = 1'b1;
    mem_wb_en_o    = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_flush_o  = 1'b0;
    mem_wb_flush_o = 1'b0;
    fault_o        = 1'b0;
    br_apply       = 1'b0;
    ld_apply       = 1'b0;
    if (state_q == FAULT) begin
      pc_en_o     = 1'b0;
      if_id_en_o  = 1'b0;
      id_ex_en_o  = 1'b0;
      ex_mem_en_o = 1'b0;
      mem_wb_en_o = 1'b0;
      fault_o     = 1'b1;
    end else if (mem_wait) begin
      // Freeze PC..EX/MEM; branch/load-stall requests stay pending in the frozen stages.
      pc_en_o        = 1'b0;
      if_id_en_o     = 1'b0;
      id_ex_en_o     = 1'b0;
      ex_mem_en_o    = 1'b0;
      mem_wb_flush_o = 1'b1;
    end else if (branch_taken_EX_i & vld_ex_q) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      br_apply      = 1'b1;
    end else if (stall_load_i & vld_id_q) begin
      pc_en_o       = 1'b0;
      if_id_en_o    = 1'b0;
      id_ex_flush_o = 1'b1;
      ld_apply      = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_wait) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d = FAULT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      vld_id_q   <= 1'b0;
      vld_ex_q   <= 1'b0;
      vld_mem_q  <= 1'b0;
      vld_wb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (if_id_en_o)  vld_id_q  <= ~if_id_flush_o;
      if (id_ex_en_o)  vld_ex_q  <= vld_id_q & ~id_ex_flush_o;
      if (ex_mem_en_o) vld_mem_q <= vld_ex_q;
      if (mem_wb_en_o) vld_wb_q  <= vld_mem_q & ~mem_wb_flush_o;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] pst_q, pmw_q, pfl_q;
  logic                 run_ok;

  assign run_ok            = (state_q != FAULT);
  assign perf_stall_load_o = pst_q;
  assign perf_mem_wait_o   = pmw_q;
  assign perf_flush_o      = pfl_q;

  // Saturating counters, frozen while faulted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pst_q <= '0;
      pmw_q <= '0;
      pfl_q <= '0;
    end else if (run_ok) begin
      if (ld_apply && pst_q != '1) pst_q <= pst_q + 1'b1;
      if (mem_wait && pmw_q != '1) pmw_q <= pmw_q + 1'b1;
      if (br_apply && pfl_q != '1) pfl_q <= pfl_q + 1'b1;
    end
  end
`endif
endmodule
